// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if
//   Control/display bundle of the 7-segment scan controller.
//   master : the side that drives the scan controls (host / testbench)
//   slave  : the scan controller itself
//   Controls  : enable, load, digits_in[4*NUM_DIGITS], dp_in[NUM_DIGITS],
//               lz_suppress, lamp_test
//   Display   : dig_en[NUM_DIGITS], dec_bcd[4], dec_enable, dec_all_on, dp,
//               frame_done
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    lz_suppress;
  logic                    lamp_test;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic [3:0]              dec_bcd;
  logic                    dec_enable;
  logic                    dec_all_on;
  logic                    dp;
  logic                    frame_done;

  modport master (
    output enable, load, digits_in, dp_in, lz_suppress, lamp_test,
    input  dig_en, dec_bcd, dec_enable, dec_all_on, dp, frame_done
  );

  modport slave (
    input  enable, load, digits_in, dp_in, lz_suppress, lamp_test,
    output dig_en, dec_bcd, dec_enable, dec_all_on, dp, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed scan controller for a common-select 7-segment display
//   sharing one BCD-to-7-segment decoder. Double-buffers the display word
//   (shadow -> active at frame boundaries), scans one digit per PRESCALE
//   cycles with a BLANK_CYCLES dark guard at the start of each slot, and
//   optionally suppresses leading zeros.
//   i_clk   : system clock (rising edge)
//   i_rst_n : asynchronous active-low reset, released through a 2-flop sync
//   bus     : seg7_scan_ctrl_if.slave (controls in, registered display out)
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  seg7_scan_ctrl_if.slave   bus
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int KW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_BLK = CW'(BLANK_CYCLES);
  localparam logic [KW-1:0] K_MAX   = KW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;

  // Reset asserts asynchronously, deasserts on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [KW-1:0]         r_k;
  logic [DW-1:0]         r_sh, r_ar;
  logic [NUM_DIGITS-1:0] r_sh_dp, r_ar_dp;
  logic [NUM_DIGITS-1:0] r_dig_en;
  logic [3:0]            r_dec_bcd;
  logic                  r_dec_enable, r_dec_all_on, r_dp, r_frame_done;

  logic [DW-1:0]         w_sh_nxt, w_ar_nxt;
  logic [NUM_DIGITS-1:0] w_sh_dp_nxt, w_ar_dp_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [KW-1:0]         w_k_nxt;
  logic                  w_boundary, w_blank_nxt, w_supp;

  // True when digit k and every digit above it are zero (digit 0 never counts).
  function automatic logic f_lead_zero(input logic [DW-1:0] d, input logic [KW-1:0] k);
    logic z;
    z = 1'b1;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (i >= int'(k) && d[4*i +: 4] != 4'd0) z = 1'b0;
    return z && (k != '0);
  endfunction

  // Outputs are registered for the slot position being entered, so the
  // active word used for them is the one that will hold after this edge;
  // that keeps digit 0 of a new frame consistent with a same-edge AR update.
  always_comb begin
    w_boundary  = (r_state != ST_IDLE) && (r_cnt == CNT_MAX) && (r_k == K_MAX);
    w_sh_nxt    = bus.load ? bus.digits_in : r_sh;
    w_sh_dp_nxt = bus.load ? bus.dp_in     : r_sh_dp;
    w_ar_nxt    = r_ar;
    w_ar_dp_nxt = r_ar_dp;
    if (r_state == ST_IDLE || w_boundary) begin
      w_ar_nxt    = w_sh_nxt;
      w_ar_dp_nxt = w_sh_dp_nxt;
    end
    w_cnt_nxt = '0;
    w_k_nxt   = '0;
    if (r_state != ST_IDLE) begin
      if (r_cnt == CNT_MAX) begin
        w_k_nxt = (r_k == K_MAX) ? '0 : r_k + 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
        w_k_nxt   = r_k;
      end
    end
    w_blank_nxt = (w_cnt_nxt < CNT_BLK);
    w_supp      = bus.lz_suppress && !bus.lamp_test && f_lead_zero(w_ar_nxt, w_k_nxt);
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_k          <= '0;
      r_sh         <= '0;
      r_ar         <= '0;
      r_sh_dp      <= '0;
      r_ar_dp      <= '0;
      r_dig_en     <= '0;
      r_dec_bcd    <= '0;
      r_dec_enable <= 1'b0;
      r_dec_all_on <= 1'b0;
      r_dp         <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_sh    <= w_sh_nxt;
      r_sh_dp <= w_sh_dp_nxt;
      r_ar    <= w_ar_nxt;
      r_ar_dp <= w_ar_dp_nxt;
      if (!bus.enable) begin
        r_state      <= ST_IDLE;
        r_cnt        <= '0;
        r_k          <= '0;
        r_dig_en     <= '0;
        r_dec_bcd    <= '0;
        r_dec_enable <= 1'b0;
        r_dec_all_on <= 1'b0;
        r_dp         <= 1'b0;
        r_frame_done <= 1'b0;
      end else begin
        r_state      <= w_blank_nxt ? ST_BLANK : ST_SHOW;
        r_cnt        <= w_cnt_nxt;
        r_k          <= w_k_nxt;
        // Decoder nibble is presented already during the guard so it settles.
        r_dec_bcd    <= w_ar_nxt[{w_k_nxt, 2'b00} +: 4];
        r_frame_done <= (w_cnt_nxt == CNT_MAX) && (w_k_nxt == K_MAX);
        if (w_blank_nxt) begin
          r_dig_en     <= '0;
          r_dec_enable <= 1'b0;
          r_dec_all_on <= 1'b0;
          r_dp         <= 1'b0;
        end else begin
          r_dig_en     <= w_supp ? '0 : (NUM_DIGITS'(1) << w_k_nxt);
          r_dec_enable <= !w_supp;
          r_dec_all_on <= bus.lamp_test;
          r_dp         <= !w_supp && w_ar_dp_nxt[w_k_nxt];
        end
      end
    end
  end

  assign bus.dig_en     = r_dig_en;
  assign bus.dec_bcd    = r_dec_bcd;
  assign bus.dec_enable = r_dec_enable;
  assign bus.dec_all_on = r_dec_all_on;
  assign bus.dp         = r_dp;
  assign bus.frame_done = r_frame_done;
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-select 7-segment display built around one shared BINARY_TO_7SEG_EN decoder. It double-buffers a packed BCD display word and steps through the digits one slot at a time. In each slot it drives the shared decoder's nibble, enable and all-on inputs and raises the matching digit-select line. A blanking guard at the start of each slot prevents ghosting, and optional leading-zero suppression blanks unused high digits.

## Interface
- NUM_DIGITS, 4, number of digits scanned; legal range 2..8.
- PRESCALE, 50000, clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 2, guard cycles at the start of each slot with all outputs dark; must be < PRESCALE.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  scan enable; low forces IDLE.
- load  input  1  one-cycle strobe; captures digits_in/dp_in into the shadow register.
- digits_in  input  4*NUM_DIGITS  packed BCD; digit k is [4k+3:4k], and digit 0 is the rightmost (LSD).
- dp_in  input  NUM_DIGITS  decimal-point request per digit.
- lz_suppress  input  1  leading-zero suppression enable.
- lamp_test  input  1  forces all segments on in every SHOW phase.
- dig_en  output  NUM_DIGITS  digit select, one-hot active-high, registered.
- dec_bcd  output  4  nibble to decoder {d,c,b,a}, registered.
- dec_enable  output  1  to decoder enable, registered.
- dec_all_on  output  1  to decoder seg7all_on, registered.
- dp  output  1  decimal point for the currently selected digit, registered.
- frame_done  output  1  one-cycle pulse at the end of each full scan.

## Operation
- Storage:
  - Shadow register (SH) is loaded from digits_in/dp_in on any cycle where load=1.
  - Active register (AR) is loaded from SH at each frame boundary.
  - If load=1 on the same cycle as a frame boundary, AR takes digits_in/dp_in directly.
  - While IDLE, AR tracks SH every cycle.
- States:
  - IDLE: all outputs 0; slot counter and digit index are held at 0. Exit to BLANK (digit 0) when enable=1.
  - BLANK: lasts BLANK_CYCLES; dig_en=0, dec_enable=0, dec_all_on=0, dp=0. dec_bcd already presents AR digit k. Goes to SHOW.
  - SHOW: lasts PRESCALE−BLANK_CYCLES cycles.
    - dig_en[k]=1, dec_bcd=AR digit k, dec_enable=1, dp=AR dp[k], dec_all_on=lamp_test.
    - At slot end, k increments and the state returns to BLANK.
    - After digit NUM_DIGITS−1, k wraps to 0; this is the frame boundary.
  - If BLANK_CYCLES=0, BLANK is skipped entirely.
- Leading-zero suppression: when lz_suppress=1 and lamp_test=0, digit k is suppressed if digits k..NUM_DIGITS−1 of AR are all 0 and k≠0.
  - A suppressed digit's SHOW phase outputs dig_en=0, dec_enable=0 and dp=0.
  - Slot timing is unchanged by suppression.
- Non-BCD nibbles (10..15) are passed to the decoder unchanged; the controller does not check them.
- enable falling in any state returns to IDLE on the next edge, and all outputs are 0 from that edge on. Re-enabling always restarts at digit 0 in BLANK.
- lamp_test, lz_suppress and dp changes take effect at the next registered output update; no frame alignment is applied.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, SH=0, AR=0, counters=0, and every output is 0.
- Reset is released synchronously by the design's reset synchronizer; the first active cycle is IDLE.
- All outputs are registered and change only on clk edges. Latency from enable=1 to the first BLANK output is one clock.
- Slot counter width is clog2(PRESCALE); it runs 0..PRESCALE−1 and resets to 0 at each slot end.
- Slot k, offset t:
  - BLANK for t<BLANK_CYCLES, SHOW otherwise.
  - Frame period is exactly NUM_DIGITS×PRESCALE cycles.
- frame_done=1 for exactly one cycle, with the counter at PRESCALE−1 and k=NUM_DIGITS−1. AR updates on the edge that ends that cycle.
- Invariant: dig_en is never multi-hot. It is 0 for at least BLANK_CYCLES between two different digits.

## Test plan
Bench parameters: NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
- **Reset:** assert rst_n=0 mid-SHOW → all outputs 0 in the same cycle (asynchronous); after release with enable=1, digit 0 BLANK starts one clock later.
- **Basic scan:** load digits_in=16'h1234, enable=1 → the following repeats with period 32 cycles:
  - dig_en=0001 with dec_bcd=4, then 0010 with 3, then 0100 with 2, then 1000 with 1.
  - Each digit is on for 6 cycles with 2 dark guard cycles between.
  - frame_done pulses once per 32 cycles.
- **Double buffer:** load 16'h5678 mid-frame → the current frame still shows 1234; the next frame shows 5678. A load on the frame_done cycle takes effect in the immediately following frame.
- **Leading zeros:** lz_suppress=1, digits_in=16'h0005 → only dig_en=0001 (dec_bcd=5) is ever asserted. With 16'h0000, digit 0 shows 0 and digits 1..3 stay dark. Setting lamp_test=1 re-enables all 4 digits with dec_all_on=1.
- **Decimal point / lamp test:** dp_in=4'b0100 → dp=1 only during digit 2 SHOW. lamp_test=1 → dec_all_on=1 during every SHOW and 0 during BLANK.
- **Enable drop:** enable=0 during the digit 2 SHOW → all outputs 0 on the next edge. Re-enable → the scan restarts at digit 0 BLANK and the frame_done spacing restarts at 32 cycles.
